// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 32/16 signed sequential divider.
package div_pkg;

    localparam int W_DVD = 32;
    localparam int W_DVS = 16;

    localparam logic [4:0]       DIV_STEPS = 5'd16;
    localparam logic [W_DVS-1:0] Q_MAX_POS = 16'd32767;
    localparam logic [W_DVS-1:0] Q_MAX_NEG = 16'd32768;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        FIX  = 3'd2,
        DONE = 3'd3,
        WAIT = 3'd4
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left one bit, subtract D when it fits.
module div_step
    import div_pkg::*;
(
    input  logic [W_DVS:0]   r_i,
    input  logic [W_DVS-1:0] q_i,
    input  logic [W_DVS:0]   d_i,
    output logic [W_DVS:0]   r_o,
    output logic [W_DVS-1:0] q_o
);

    logic [W_DVS+1:0] shifted;

    assign shifted = {r_i, q_i[W_DVS-1]};

    always_comb begin
        r_o = shifted[W_DVS:0];
        q_o = {q_i[W_DVS-2:0], 1'b0};
        if (shifted >= {1'b0, d_i}) begin
            r_o = shifted[W_DVS:0] - d_i;
            q_o = {q_i[W_DVS-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div3216.sv
// Sequential 32/16 signed divider: 16 restoring steps on magnitudes, then a sign-fix cycle.
// DIV_FAST_ZERO_EN: divide-by-zero skips RUN/FIX and reports from IDLE straight to DONE.
module div3216
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic [W_DVD-1:0] dividend,
    input  logic [W_DVS-1:0] divisor,
    output logic             done,
    output logic [W_DVS-1:0] quotient,
    output logic [W_DVS-1:0] remainder,
    output logic             overflow,
    output logic             divzero,
    output state_e           state_o
);

    state_e           state_q;
    logic [W_DVS:0]   r_q, r_d, dvs_q;
    logic [W_DVS-1:0] q_q, q_d;
    logic [4:0]       cnt_q;
    logic             qneg_q, rneg_q, eovf_q, edz_q;
    logic [W_DVS-1:0] quot_q, rem_q;
    logic             ovf_q, dz_q;

    logic [W_DVD-1:0] dvd_abs;
    logic [W_DVS:0]   dvs_abs;
    logic             fix_ovf;

    // Magnitudes are unsigned, so -2^31 and -32768 map to their exact positive values.
    assign dvd_abs = dividend[W_DVD-1] ? -dividend : dividend;
    assign dvs_abs = {1'b0, (divisor[W_DVS-1] ? -divisor : divisor)};

    assign fix_ovf = eovf_q
                   | (!qneg_q && (q_q > Q_MAX_POS))
                   | ( qneg_q && (q_q > Q_MAX_NEG));

    div_step u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (dvs_q),
        .r_o (r_d),
        .q_o (q_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            eovf_q  <= 1'b0;
            edz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ready) begin
                        qneg_q  <= dividend[W_DVD-1] ^ divisor[W_DVS-1];
                        rneg_q  <= dividend[W_DVD-1];
                        r_q     <= {1'b0, dvd_abs[W_DVD-1:W_DVS]};
                        q_q     <= dvd_abs[W_DVS-1:0];
                        dvs_q   <= dvs_abs;
                        cnt_q   <= DIV_STEPS;
                        // A high half not below the divisor guarantees |quotient| >= 2^16.
                        eovf_q  <= (dvs_abs == '0)
                                 | ({1'b0, dvd_abs[W_DVD-1:W_DVS]} >= dvs_abs);
                        edz_q   <= (divisor == '0);
`ifdef DIV_FAST_ZERO_EN
                        if (divisor == '0) begin
                            quot_q  <= '0;
                            rem_q   <= '0;
                            ovf_q   <= 1'b1;
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
`else
                        state_q <= RUN;
`endif
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (fix_ovf) begin
                        quot_q <= '0;
                        rem_q  <= '0;
                        ovf_q  <= 1'b1;
                        dz_q   <= edz_q;
                    end else begin
                        quot_q <= qneg_q ? -q_q : q_q;
                        rem_q  <= rneg_q ? -r_q[W_DVS-1:0] : r_q[W_DVS-1:0];
                        ovf_q  <= 1'b0;
                        dz_q   <= 1'b0;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= ready ? WAIT : IDLE;
                end
                WAIT: begin
                    if (!ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign overflow  = ovf_q;
    assign divzero   = dz_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_div3216.sv
// Scoreboard bench for div3216: driver pushes reference results, a monitor pops them on done.
// Honours DIV_FAST_ZERO_EN for the expected divide-by-zero latency.
module tb_div3216;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        overflow;
    logic        divzero;
    state_e      state_o;

    logic [33:0] exp_q[$];
    int          exp_cyc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    div3216 dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow),
        .divzero   (divzero),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed arithmetic, packed as {q, r, overflow, divzero}.
    function automatic logic [33:0] ref_div(input logic signed [31:0] a, input logic signed [15:0] b);
        longint q;
        longint r;
        logic [15:0] qq;
        logic [15:0] rr;
        if (b == 0) return {32'h0, 1'b1, 1'b1};
        q = longint'(a) / longint'(b);
        r = longint'(a) % longint'(b);
        if (q > 32767 || q < -32768) return {32'h0, 1'b1, 1'b0};
        qq = q[15:0];
        rr = r[15:0];
        return {qq, rr, 2'b00};
    endfunction

    function automatic int ref_latency(input logic [15:0] b);
`ifdef DIV_FAST_ZERO_EN
        if (b == 16'h0) return 0;
`endif
        return 17;
    endfunction

    always @(negedge clk) begin : monitor
        logic [33:0] e;
        int          c;
        if (!reset && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                chk("result{q,r,ovf,dz}", {quotient, remainder, overflow, divzero}, e);
                chk("done_cycle", cyc, c);
            end
        end
    end

    // hold=0 leaves ready high on return; otherwise ready drops after hold cycles.
    task automatic issue(input logic [31:0] a, input logic [15:0] b, input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (state_o !== IDLE && n < 200) begin
            dividend = $urandom;
            divisor  = 16'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: state %0d expected IDLE within 200 cycles", state_o);
            return;
        end
        ready    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        exp_q.push_back(ref_div(a, b));
        exp_cyc_q.push_back(cyc + ref_latency(b));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            ready    = 1'b0;
            dividend = $urandom;
            divisor  = 16'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    logic [31:0] dir_a[10] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_8000,
                               32'h0000_8000, 32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1234};
    logic [15:0] dir_b[10] = '{16'd7, 16'd7, 16'hFFF9, 16'hFFF9, 16'd1,
                               16'd1, 16'd1, 16'hFFFF, 16'h7FFF, 16'd0};

    initial begin
        logic [31:0] a;
        logic [31:0] t;
        logic [15:0] b;
        reset    = 1'b1;
        ready    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", state_o, IDLE);
        chk("reset_outputs", {done, quotient, remainder, overflow, divzero}, 35'h0);
        reset = 1'b0;

        // Signs of 100/7 and the range / divide-by-zero edges.
        for (int i = 0; i < 10; i++) begin
            issue(dir_a[i], dir_b[i], 1);
            drain();
        end

        // Held ready: one result, then parked in WAIT with outputs held.
        issue(32'd1000, 16'd10, 0);
        repeat (60) @(negedge clk);
        chk("held_ready_state", state_o, WAIT);
        chk("held_ready_quotient", {quotient, remainder}, {16'd100, 16'd0});
        ready = 1'b0;
        issue(32'd1001, 16'd10, 1);
        drain();

        // Reset during RUN cycle 8 aborts without a done pulse.
        issue(32'd77777, 16'd3, 1);
        repeat (7) @(negedge clk);
        chk("pre_reset_state", state_o, RUN);
        reset = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        chk("abort_state", state_o, IDLE);
        chk("abort_outputs", {done, quotient, remainder, overflow, divzero}, 35'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        issue(32'd50, 16'd5, 1);
        drain();

        // Random signed operands with a mix of magnitudes.
        for (int i = 0; i < 2000; i++) begin
            t = $urandom;
            case ($urandom_range(0, 3))
                0:       a = t;
                1:       a = {{12{t[19]}}, t[19:0]};
                2:       a = {{16{t[15]}}, t[15:0]};
                default: a = {{8{t[23]}}, t[23:0]};
            endcase
            case ($urandom_range(0, 9))
                0:       b = 16'h0;
                1:       b = 16'h8000;
                2:       b = 16'hFFFF;
                3:       b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            issue(a, b, $urandom_range(1, 3));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
